// File: rtl/pc_gen.sv
// Next-PC generator: sequential/branch/jump/register targets with misalign trap.
// Define PC_GEN_RAS_EN to build in the return-address stack used by JAL/JALR/RET.
module pc_gen #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
  parameter int          RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         exc_req,
  input  logic [2:0]                   npc_op,
  input  logic                         br_taken,
  input  logic [25:0]                  imm,
  input  logic [31:0]                  rs,
  output logic [31:0]                  pc,
  output logic [31:0]                  pc_plus4,
  output logic [31:0]                  npc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         misalign
);

  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_JUMPR  = 3'b011;
  localparam logic [2:0] OP_JAL    = 3'b100;
  localparam logic [2:0] OP_JALR   = 3'b101;
  localparam logic [2:0] OP_RET    = 3'b110;

  logic [31:0] br_off;
  logic [31:0] jmp_tgt;
  logic [31:0] reg_tgt;
  logic        reg_op;
  logic        bad_tgt;

`ifdef PC_GEN_RAS_EN
  localparam int             PW      = $clog2(RAS_DEPTH);
  localparam int             CW      = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(RAS_DEPTH);

  logic [31:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0] ras_ptr;
  logic [31:0]   ras_top;
  logic          update;
  logic          push;
  logic          pop;

  // ras_ptr addresses the next free slot; the top entry sits one below it.
  assign ras_top = ras_mem[ras_ptr - PW'(1)];
  assign update  = !rst && !exc_req && !stall;
`endif

  assign pc_plus4 = pc + 32'd4;
  assign br_off   = {{14{imm[15]}}, imm[15:0], 2'b00};
  assign jmp_tgt  = {pc_plus4[31:28], imm, 2'b00};

  always_comb begin
    npc     = pc_plus4;
    reg_op  = 1'b0;
    reg_tgt = rs;
    case (npc_op)
      OP_BRANCH: if (br_taken) npc = pc_plus4 + br_off;
      OP_JUMP:   npc = jmp_tgt;
      OP_JUMPR:  reg_op = 1'b1;
      OP_JAL:    npc = jmp_tgt;
      OP_JALR:   reg_op = 1'b1;
      OP_RET: begin
        reg_op = 1'b1;
`ifdef PC_GEN_RAS_EN
        if (ras_count != '0) reg_tgt = ras_top;
`endif
      end
      default: npc = pc_plus4;
    endcase
    bad_tgt = reg_op && (reg_tgt[1:0] != 2'b00);
    if (reg_op) npc = bad_tgt ? EXC_VEC : reg_tgt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else if (exc_req) begin
      pc       <= EXC_VEC;
      misalign <= 1'b0;
    end else if (stall) begin
      misalign <= 1'b0;
    end else begin
      pc       <= npc;
      misalign <= bad_tgt;
    end
  end

`ifdef PC_GEN_RAS_EN
  // A misaligned JALR traps instead of calling, so nothing is pushed; RET pops regardless.
  always_comb begin
    push = update && ((npc_op == OP_JAL) || ((npc_op == OP_JALR) && !bad_tgt));
    pop  = update && (npc_op == OP_RET) && (ras_count != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ras_ptr   <= '0;
      ras_count <= '0;
    end else if (push) begin
      ras_ptr <= ras_ptr + PW'(1);
      if (ras_count != DEPTH_C) ras_count <= ras_count + CW'(1);
    end else if (pop) begin
      ras_ptr   <= ras_ptr - PW'(1);
      ras_count <= ras_count - CW'(1);
    end
  end

  // Wrapping pointer overwrites the oldest entry once the stack is full.
  always_ff @(posedge clk) begin
    if (push) ras_mem[ras_ptr] <= pc_plus4;
  end
`else
  assign ras_count = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Randomized + directed bench for pc_gen: queue-based reference model and scoreboard.
// Follows the RAS build when PC_GEN_RAS_EN is defined.
module tb_pc_gen;
  localparam int          RAS_DEPTH = 4;
  localparam logic [31:0] RST_PC    = 32'h0000_3000;
  localparam logic [31:0] EXC       = 32'h0000_4180;
`ifdef PC_GEN_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk;
  logic        rst, stall, exc_req, br_taken;
  logic [2:0]  npc_op;
  logic [25:0] imm;
  logic [31:0] rs;
  logic [31:0] pc, pc_plus4, npc;
  logic [$clog2(RAS_DEPTH):0] ras_count;
  logic        misalign;

  pc_gen #(.RESET_PC(RST_PC), .EXC_VEC(EXC), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .exc_req(exc_req), .npc_op(npc_op),
    .br_taken(br_taken), .imm(imm), .rs(rs), .pc(pc), .pc_plus4(pc_plus4),
    .npc(npc), .ras_count(ras_count), .misalign(misalign));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit mis; int cnt; } st_t;
  typedef struct { logic [31:0] npc; logic [31:0] p4; } cb_t;
  st_t st_q[$];
  cb_t cb_q[$];
  int  checks = 0;
  int  failures = 0;

  logic [31:0] m_pc;
  bit          m_mis;
  bit          m_valid = 1'b0;
  logic [31:0] m_ras[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit s, input logic [2:0] op,
                      input bit br, input logic [25:0] im, input logic [31:0] rv);
    logic [31:0] p4, tgt, nx;
    logic signed [31:0] off;
    bit regop, bad;
    cb_t c;
    st_t t;
    @(negedge clk);
    rst = r; exc_req = e; stall = s; npc_op = op; br_taken = br; imm = im; rs = rv;
    p4 = m_pc + 32'd4;
    nx = p4;
    tgt = rv;
    regop = 1'b0;
    case (op)
      3'd1: if (br) begin off = $signed(im[15:0]); nx = p4 + off * 4; end
      3'd2, 3'd4: nx = (p4 & 32'hF000_0000) | (32'(im) << 2);
      3'd3, 3'd5: regop = 1'b1;
      3'd6: begin regop = 1'b1; if (RAS_ON && m_ras.size() > 0) tgt = m_ras[$]; end
      default: nx = p4;
    endcase
    bad = regop && ((tgt & 32'd3) != 0);
    if (regop) nx = bad ? EXC : tgt;
    if (m_valid) begin c.npc = nx; c.p4 = p4; cb_q.push_back(c); end
    if (r) begin
      m_pc = RST_PC; m_mis = 0; m_ras.delete(); m_valid = 1'b1;
    end else if (e) begin
      m_pc = EXC; m_mis = 0;
    end else if (s) begin
      m_mis = 0;
    end else begin
      m_pc = nx; m_mis = bad;
      if (RAS_ON) begin
        if (op == 3'd4 || (op == 3'd5 && !bad)) begin
          m_ras.push_back(p4);
          if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end else if (op == 3'd6 && m_ras.size() > 0) begin
          void'(m_ras.pop_back());
        end
      end
    end
    if (m_valid) begin
      t.pc = m_pc; t.mis = m_mis; t.cnt = RAS_ON ? m_ras.size() : 0;
      st_q.push_back(t);
    end
  endtask

  task automatic op1(input logic [2:0] op, input logic [25:0] im, input logic [31:0] rv);
    step(0, 0, 0, op, 1'b0, im, rv);
  endtask

  // Monitor: registered state after each edge.
  initial forever begin
    st_t t;
    @(posedge clk); #1;
    if (st_q.size() > 0) begin
      t = st_q.pop_front();
      chk("pc", pc, t.pc);
      chk("misalign", 32'(misalign), 32'(t.mis));
      chk("ras_count", 32'(ras_count), 32'(t.cnt));
    end
  end

  // Monitor: combinational outputs once the driven inputs settle.
  initial forever begin
    cb_t c;
    @(negedge clk); #2;
    if (cb_q.size() > 0) begin
      c = cb_q.pop_front();
      chk("npc", npc, c.npc);
      chk("pc_plus4", pc_plus4, c.p4);
    end
  end

  initial begin
    rst = 1; stall = 0; exc_req = 0; npc_op = 0; br_taken = 0; imm = 0; rs = 0;
    // sequential fetch
    step(1, 0, 0, 3'd0, 0, 0, 0);
    repeat (4) op1(3'd0, 0, 0);
    // branch back taken from 0x3010
    step(0, 0, 0, 3'd1, 1, 26'h000FFFE, 0);
    step(1, 0, 0, 3'd0, 0, 0, 0);
    repeat (4) op1(3'd0, 0, 0);
    step(0, 0, 0, 3'd1, 0, 26'h000FFFE, 0);
    step(0, 0, 0, 3'd1, 1, 26'h0000010, 0);
    // call and return
    step(1, 0, 0, 3'd0, 0, 0, 0);
    op1(3'd4, 26'h0000400, 0);
    op1(3'd6, 0, 32'h0);
    // stack overflow then drain
    step(1, 0, 0, 3'd0, 0, 0, 0);
    for (int i = 0; i < 5; i++) op1(3'd4, 26'h0000400 + 26'(i * 'h100), 0);
    for (int i = 0; i < 5; i++) op1(3'd6, 0, 32'h0000_5000);
    // misaligned register targets and exception under stall
    step(1, 0, 0, 3'd0, 0, 0, 0);
    op1(3'd3, 0, 32'h0000_3002);
    op1(3'd0, 0, 0);
    step(0, 1, 1, 3'd0, 0, 0, 0);
    op1(3'd0, 0, 0);
    op1(3'd5, 0, 32'h0000_2001);
    op1(3'd6, 0, 32'h0000_3003);
    op1(3'd5, 0, 32'h0000_2000);
    op1(3'd3, 0, 32'h0000_3001);
    step(0, 0, 1, 3'd3, 0, 0, 32'h0000_3001);
    step(0, 0, 1, 3'd0, 0, 0, 0);
    op1(3'd7, 0, 0);
    op1(3'd6, 0, 32'h0000_3100);
    // call then return via rs when the stack is compiled out
    step(1, 0, 0, 3'd0, 0, 0, 0);
    op1(3'd4, 26'h0000400, 0);
    op1(3'd6, 0, 32'h0000_3100);
    // randomized
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rv;
      rv = $urandom();
      if ($urandom_range(0, 4) != 0) rv[1:0] = 2'b00;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 26'($urandom()), rv);
    end
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(st_q.size() + cb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
